// File: rtl/taxi_apb_arb_pkg.sv
// taxi_apb_arb_pkg: shared state encoding and round-robin pick helper for taxi APB arbiters.
package taxi_apb_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } pick_t;

    // First set request at or after ptr+1 (mod n); ptr itself has lowest priority.
    function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 16; k >= 1; k--) begin
            if (k <= n) begin
                j = (int'(ptr) + k) % n;
                if (req[j[3:0]]) begin
                    p.valid = 1'b1;
                    p.idx   = j[3:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/taxi_rr_sel.sv
// taxi_rr_sel: combinational round-robin selector over up to 16 requests.
module taxi_rr_sel
    import taxi_apb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    pick_t p;

    always_comb begin
        p     = rr_pick(16'(req), 4'(ptr), N);
        idx   = IW'(p.idx);
        valid = p.valid;
    end

endmodule

// File: rtl/taxi_apb_rr_arb.sv
// taxi_apb_rr_arb: round-robin arbiter sharing one APB completer between N requesters.
// Define TAXI_APB_RR_ARB_TIMEOUT_EN to bound each ACCESS phase to TIMEOUT cycles.
module taxi_apb_rr_arb
    import taxi_apb_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        s_psel,
    input  logic [N-1:0]        s_penable,
    input  logic [N-1:0]        s_pwrite,
    input  logic [N*ADDR_W-1:0] s_paddr,
    input  logic [N*DATA_W-1:0] s_pwdata,
    input  logic [N*STRB_W-1:0] s_pstrb,
    output logic [N-1:0]        s_pready,
    output logic [DATA_W-1:0]   s_prdata,
    output logic [N-1:0]        s_pslverr,
    output logic                m_psel,
    output logic                m_penable,
    output logic                m_pwrite,
    output logic [ADDR_W-1:0]   m_paddr,
    output logic [DATA_W-1:0]   m_pwdata,
    output logic [STRB_W-1:0]   m_pstrb,
    input  logic [DATA_W-1:0]   m_prdata,
    input  logic                m_pready,
    input  logic                m_pslverr
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t              state_q, state_d;
    logic [IW-1:0]       grant_q, grant_d, ptr_q, ptr_d, pick_idx;
    logic                pick_valid, tmo;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [N-1:0]        pready_q, pready_d, pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                unused_penable;

    // Requesters need not raise penable to be granted; it carries no information here.
    assign unused_penable = ^s_penable;

    taxi_rr_sel #(.N(N), .IW(IW)) u_sel (
        .req   (s_psel),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef TAXI_APB_RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP)
            cnt_d = '0;
        else if (state_q == ACCESS && !m_pready)
            cnt_d = cnt_q + 1'b1;
        tmo = state_q == ACCESS && !m_pready && (cnt_q + 1'b1) == CW'(TIMEOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign tmo            = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pready_d  = '0;
        pslverr_d = '0;
        prdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = SETUP;
                    grant_d  = pick_idx;
                    pwrite_d = s_pwrite[pick_idx];
                    paddr_d  = s_paddr[pick_idx*ADDR_W +: ADDR_W];
                    pwdata_d = s_pwdata[pick_idx*DATA_W +: DATA_W];
                    pstrb_d  = s_pstrb[pick_idx*STRB_W +: STRB_W];
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A completion in the timeout cycle wins over the forced error.
                if (m_pready || tmo) begin
                    state_d            = RESP;
                    pready_d[grant_q]  = 1'b1;
                    pslverr_d[grant_q] = m_pready ? m_pslverr : 1'b1;
                    prdata_d           = m_pready ? m_prdata : '0;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pready_q  <= '0;
            pslverr_q <= '0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign m_psel    = state_q == SETUP || state_q == ACCESS;
    assign m_penable = state_q == ACCESS;
    assign m_pwrite  = pwrite_q;
    assign m_paddr   = paddr_q;
    assign m_pwdata  = pwdata_q;
    assign m_pstrb   = pstrb_q;
    assign s_pready  = pready_q;
    assign s_pslverr = pslverr_q;
    assign s_prdata  = prdata_q;

endmodule

// File: tb/tb_taxi_apb_rr_arb.sv
// tb_taxi_apb_rr_arb: directed checks of the round-robin APB arbiter with four requesters.
module tb_taxi_apb_rr_arb;

    localparam int N = 4, AW = 18, DW = 16, SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  s_psel = '0, s_penable = '0, s_pwrite = '0;
    logic [N*AW-1:0] s_paddr = '0;
    logic [N*DW-1:0] s_pwdata = '0;
    logic [N*SW-1:0] s_pstrb = '0;
    logic [N-1:0]  s_pready, s_pslverr;
    logic [DW-1:0] s_prdata;
    logic          m_psel, m_penable, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata;
    logic [SW-1:0] m_pstrb;
    logic [DW-1:0] m_prdata = '0;
    logic          m_pready = 1'b0;
    logic          m_pslverr;
    logic          err_en = 1'b0;
    int            checks = 0, errors = 0;

    // Completer model: flags an error on any access to address 2 when enabled.
    assign m_pslverr = err_en && m_paddr == 18'd2;

    always #5 clk = ~clk;

    taxi_apb_rr_arb #(.N(N), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_psel"}, 64'(m_psel), 64'd0);
        chk({tag, "_penable"}, 64'(m_penable), 64'd0);
        chk({tag, "_pready"}, 64'(s_pready), 64'd0);
        chk({tag, "_pslverr"}, 64'(s_pslverr), 64'd0);
    endtask

    initial begin
        #1;
        chk_idle("rst");
        chk("rst_prdata", 64'(s_prdata), 64'd0);
        chk("rst_paddr", 64'(m_paddr), 64'd0);
        chk("rst_pwdata", 64'(m_pwdata), 64'd0);
        chk("rst_pstrb", 64'(m_pstrb), 64'd0);
        chk("rst_pwrite", 64'(m_pwrite), 64'd0);
        step();
        step();
        rst = 1'b0;

        // Zero-wait write from requester 0
        s_psel = 4'b0001; s_pwrite = 4'b0001;
        s_paddr[0 +: AW] = 18'h00123; s_pwdata[0 +: DW] = 16'hBEEF; s_pstrb[0 +: SW] = 2'b11;
        m_pready = 1'b1;
        step();
        chk("wr_setup_psel", 64'(m_psel), 64'd1);
        chk("wr_setup_penable", 64'(m_penable), 64'd0);
        chk("wr_paddr", 64'(m_paddr), 64'h00123);
        chk("wr_pwdata", 64'(m_pwdata), 64'hBEEF);
        chk("wr_pstrb", 64'(m_pstrb), 64'd3);
        chk("wr_pwrite", 64'(m_pwrite), 64'd1);
        chk("wr_setup_pready", 64'(s_pready), 64'd0);
        step();
        chk("wr_access_psel", 64'(m_psel), 64'd1);
        chk("wr_access_penable", 64'(m_penable), 64'd1);
        chk("wr_access_pready", 64'(s_pready), 64'd0);
        step();
        chk("wr_resp_pready", 64'(s_pready), 64'b0001);
        chk("wr_resp_pslverr", 64'(s_pslverr), 64'd0);
        chk("wr_resp_psel", 64'(m_psel), 64'd0);
        s_psel = '0;
        step();
        chk_idle("wr_idle");

        // Read from requester 0 with three wait states; later input changes ignored
        s_psel = 4'b0001; s_pwrite = 4'b0000; s_paddr[0 +: AW] = 18'h31234;
        m_pready = 1'b0;
        step();
        chk("rd_setup_paddr", 64'(m_paddr), 64'h31234);
        chk("rd_setup_pwrite", 64'(m_pwrite), 64'd0);
        s_paddr[0 +: AW] = 18'h0FFFF; s_pwrite = 4'b0001; s_psel = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_wait_penable", 64'(m_penable), 64'd1);
            chk("rd_wait_psel", 64'(m_psel), 64'd1);
            chk("rd_wait_paddr", 64'(m_paddr), 64'h31234);
            chk("rd_wait_pwrite", 64'(m_pwrite), 64'd0);
            chk("rd_wait_pready", 64'(s_pready), 64'd0);
        end
        step();
        m_pready = 1'b1; m_prdata = 16'h5A5A;
        chk("rd_last_penable", 64'(m_penable), 64'd1);
        step();
        chk("rd_resp_pready", 64'(s_pready), 64'b0001);
        chk("rd_resp_prdata", 64'(s_prdata), 64'h5A5A);
        chk("rd_resp_pslverr", 64'(s_pslverr), 64'd0);
        m_prdata = '0;
        step();
        chk_idle("rd_idle");
        chk("rd_idle_prdata", 64'(s_prdata), 64'd0);

        // All four requesting: rotation starting after last grant 0; requester 2 errors
        s_psel = 4'b1111; s_pwrite = 4'b1111; err_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            s_paddr[i*AW +: AW] = AW'(i);
            s_pwdata[i*DW +: DW] = DW'(16'hA000 + i);
        end
        for (int k = 0; k < 8; k++) begin
            automatic int g = (k + 1) % N;
            step();
            chk("rr_paddr", 64'(m_paddr), 64'(g));
            chk("rr_pwdata", 64'(m_pwdata), 64'(16'hA000 + g));
            step();
            step();
            chk("rr_pready", 64'(s_pready), 64'(1 << g));
            chk("rr_pslverr", 64'(s_pslverr), (g == 2) ? 64'b0100 : 64'd0);
            step();
            chk("rr_idle_pready", 64'(s_pready), 64'd0);
        end
        s_psel = '0; err_en = 1'b0;
        step();

`ifdef TAXI_APB_RR_ARB_TIMEOUT_EN
        // Completer never ready: forced error after 16 ACCESS cycles, then requester 2
        s_psel = 4'b0110; m_pready = 1'b0; m_prdata = 16'hFFFF;
        step();
        chk("to_setup_paddr", 64'(m_paddr), 64'd1);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("to_access_penable", 64'(m_penable), 64'd1);
            chk("to_access_pready", 64'(s_pready), 64'd0);
        end
        step();
        chk("to_resp_pready", 64'(s_pready), 64'b0010);
        chk("to_resp_pslverr", 64'(s_pslverr), 64'b0010);
        chk("to_resp_prdata", 64'(s_prdata), 64'd0);
        s_psel = 4'b0100; m_pready = 1'b1; m_prdata = '0;
        step();
        chk_idle("to_idle");
        step();
        chk("to_next_paddr", 64'(m_paddr), 64'd2);
        step();
        step();
        chk("to_next_pready", 64'(s_pready), 64'b0100);
        s_psel = '0;
        step();
`endif

        // Move the pointer to 1, start a grant to 0, then reset during ACCESS
        s_psel = 4'b0010; m_pready = 1'b1;
        step();
        chk("pre_paddr", 64'(m_paddr), 64'd1);
        step();
        step();
        chk("pre_pready", 64'(s_pready), 64'b0010);
        s_psel = 4'b0011; m_pready = 1'b0;
        step();
        step();
        chk("pre_rst_paddr", 64'(m_paddr), 64'd0);
        step();
        chk("pre_rst_penable", 64'(m_penable), 64'd1);
        rst = 1'b1;
        #1;
        chk_idle("arst");
        chk("arst_paddr", 64'(m_paddr), 64'd0);
        step();
        rst = 1'b0;
        m_pready = 1'b1;
        step();
        chk("post_rst_psel", 64'(m_psel), 64'd1);
        chk("post_rst_paddr", 64'(m_paddr), 64'd1);
        step();
        step();
        chk("post_rst_pready", 64'(s_pready), 64'b0010);
        step();
        step();
        chk("post_rst_second", 64'(m_paddr), 64'd0);
        s_psel = '0;
        step();
        step();
        chk("post_rst_pready0", 64'(s_pready), 64'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/taxi_apb_rr_arb.md
Name: taxi_apb_rr_arb

Overview:
- Round-robin arbiter that shares one APB completer port between N APB requesters.
- Target is the transceiver control port of the 25G MAC/GT wrapper: ADDR_W 18, DATA_W 16.
- Typical requesters are the driver register bridge, the link-training/reset sequencer and the eye-scan engine.
- Serialises whole APB transfers, returns each response to the requester that issued it, and optionally bounds each access with a timeout.

Parameters:
- N, 2: number of requester ports (1..16).
- ADDR_W, 18: APB address width.
- DATA_W, 16: APB data width.
- STRB_W, DATA_W/8: strobe width.
- TIMEOUT, 1024: cycles in ACCESS before forced termination. Used only with the optional feature.

Ports:
- clk  in  1  block clock.
- rst  in  1  reset, asynchronous, active-high.
- s_psel  in  N  per-requester select.
- s_penable  in  N  per-requester enable.
- s_pwrite  in  N  per-requester write flag.
- s_paddr  in  N*ADDR_W  per-requester address, packed, requester i at [i*ADDR_W +: ADDR_W].
- s_pwdata  in  N*DATA_W  per-requester write data, packed.
- s_pstrb  in  N*STRB_W  per-requester strobes, packed.
- s_pready  out  N  per-requester ready.
- s_prdata  out  DATA_W  read data, shared; valid only with the asserted s_pready bit.
- s_pslverr  out  N  per-requester error.
- m_psel  out  1  completer select.
- m_penable  out  1  completer enable.
- m_pwrite  out  1  completer write flag.
- m_paddr  out  ADDR_W  completer address.
- m_pwdata  out  DATA_W  completer write data.
- m_pstrb  out  STRB_W  completer strobes.
- m_prdata  in  DATA_W  completer read data.
- m_pready  in  1  completer ready.
- m_pslverr  in  1  completer error.
- Interface fixed: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, grant index 0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: requests are the set of s_psel bits. If any bit is set, pick the first set index at or after ptr+1 (mod N). Latch grant g plus s_pwrite, s_paddr, s_pwdata and s_pstrb of g, then go to SETUP. Requester penable is not required for arbitration.
- SETUP (one cycle): m_psel=1, m_penable=0, m_* driven from the latched registers. Always goes to ACCESS.
- ACCESS: m_psel=1, m_penable=1.
  - When m_pready=1: latch m_prdata and m_pslverr, go to RESP.
  - m_* stay stable for the whole of ACCESS.
- RESP (one cycle): s_pready[g]=1, s_prdata=latched data, s_pslverr[g]=latched error. Set ptr=g, go to IDLE.
- All s_pready, s_prdata and s_pslverr bits are registered. Only bit g can be 1, and only in RESP.
- Latency: s_psel rises in cycle T (state IDLE) → m_psel at T+1, m_penable at T+2. If the completer is zero-wait, s_pready[g] is at T+3.
- Back-to-back: the mandatory IDLE cycle after RESP gives a minimum of 4 cycles per transfer.
- Fairness: after a grant to g, every other pending requester is served before g again.
- Granted requester drops s_psel mid-transfer (protocol violation): the completer transfer runs to completion and the response pulse is still issued. No retraction of m_psel.
- Requester signals are sampled only in IDLE. Later changes are ignored.
- N=1: ptr stays 0; behaviour is otherwise identical.
- Reset asserted mid-transfer: immediate return to the reset values above; the completer sees m_psel drop.

Optional Feature:
- Macro: TAXI_APB_RR_ARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entry to ACCESS and increments each ACCESS cycle without m_pready.
  - When the count reaches TIMEOUT, leave ACCESS → RESP with s_prdata=0 and s_pslverr[g]=1.
  - m_pready in the timeout cycle takes priority: a normal completion is reported.
- Undefined: no counter logic; ACCESS waits indefinitely.

Decomposition:
- Package taxi_apb_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP, 2-bit).
  - function rr_pick(req, ptr, N) returning the index and a valid flag.
- Sub-module taxi_rr_sel: combinational round-robin selector, reusable by other taxi arbiters.

Test Plan:
- N=2, zero-wait completer. Requester 0 writes addr 0x0_0123, data 0xBEEF → m_paddr=0x00123, m_pwdata=0xBEEF. m_psel at T+1, m_penable at T+2, s_pready[0] at T+3, s_pready[1] never asserted.
- Read, completer inserts 3 wait states and returns 0x5A5A → s_prdata=0x5A5A with s_pready[0] at T+6. m_* stable across all ACCESS cycles.
- N=4, all s_psel held high for 8 transfers → grant order 1,2,3,0,1,2,3,0; exactly one s_pready bit per RESP.
- Completer returns m_pslverr=1 on requester 2's write → s_pslverr[2]=1 for one cycle, s_pslverr of others 0.
- Macro defined, TIMEOUT=16, m_pready tied low → s_pready[g]=1, s_pslverr[g]=1, s_prdata=0 after 16 ACCESS cycles. Then IDLE, and the next requester is granted.
- rst asserted during ACCESS → all outputs 0 asynchronously, ptr=0. After release, the pending requests of 1 and 0 are granted 1 first.
